// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared channel state, mode encodings and reset terminal count
package tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // One-second tick at the given clock rate, clipped to the counter width.
    function automatic logic [63:0] reset_tc(input int clk_hz, input int w);
        logic [63:0] v;
        v = 64'(clk_hz) - 64'd1;
        if (w < 64) begin
            v = v & ((64'd1 << w) - 64'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_gen_n_chan.sv
// rtl/tick_gen_n_chan.sv - one tick channel: IDLE/RUN state, counter, terminal count, rco
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int            W      = 32,
    parameter logic [W-1:0]  TC_RST = '1
) (
    input  logic         mclk,
    input  logic         reset,
    input  logic         en,
    input  logic         mode,
    input  logic         cas_ok,
    input  logic         start,
    input  logic         stop,
    input  logic         tc_wr,
    input  logic [W-1:0] tc_wdata,
    output logic         rco,
    output logic         busy,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    chan_state_t  state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] tc_q;
    logic         rco_q, rco_d;
    logic         adv;

    assign adv = (state_q == RUN) && en && cas_ok;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rco_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rco_q   <= rco_d;
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            tc_q <= TC_RST;
        end else if (tc_wr) begin
            tc_q <= tc_wdata;
        end
    end

    // Stop outranks start, start outranks counting; >= lets a lowered tc wrap at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rco_d   = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (adv) begin
            if (cnt_q >= tc_q) begin
                cnt_d = '0;
                rco_d = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    state_d = IDLE;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign rco  = rco_q;
    assign busy = (state_q == RUN);
    assign cnt  = cnt_q;

endmodule

// File: rtl/tick_gen_n.sv
// rtl/tick_gen_n.sv - multi-channel tick generator: write decode and cascade wiring
module tick_gen_n
    import tick_gen_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int NCH    = 4,
    parameter int W      = 32,
    parameter int AW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic [NCH-1:0]   casc,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    input  logic             wr,
    input  logic [AW-1:0]    wr_ch,
    input  logic [W-1:0]     wr_data,
    output logic [NCH-1:0]   rco,
    output logic [NCH-1:0]   busy,
    output logic [NCH*W-1:0] cnt
);

    localparam logic [W-1:0] TC_RST = W'(reset_tc(CLK_HZ, W));

    // Channel 0 has no upstream neighbour, so its cascade select has no effect.
    logic casc0_unused;
    assign casc0_unused = casc[0];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic cas_ok;
        logic tc_wr;

        if (i == 0) begin : g_head
            assign cas_ok = 1'b1;
        end else begin : g_link
            assign cas_ok = ~casc[i] | rco[i-1];
        end

        assign tc_wr = wr && (wr_ch == AW'(i));

        tick_chan #(
            .W      (W),
            .TC_RST (TC_RST)
        ) u_chan (
            .mclk     (mclk),
            .reset    (reset),
            .en       (en[i]),
            .mode     (mode[i]),
            .cas_ok   (cas_ok),
            .start    (start[i]),
            .stop     (stop[i]),
            .tc_wr    (tc_wr),
            .tc_wdata (wr_data),
            .rco      (rco[i]),
            .busy     (busy[i]),
            .cnt      (cnt[i*W +: W])
        );
    end

endmodule

// File: tb/tb_tick_gen_n.sv
// tb/tb_tick_gen_n.sv - directed self-checking bench for tick_gen_n
module tb_tick_gen_n;

    localparam int NCH = 2;
    localparam int W   = 8;

    logic         mclk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   en = '0, mode = '0, casc = '0, start = '0, stop = '0;
    logic         wr = 1'b0;
    logic         wr_ch = 1'b0;
    logic [7:0]   wr_data = '0;
    logic [1:0]   rco, busy;
    logic [15:0]  cnt;

    int vectors = 0;
    int miscompares = 0;
    int n;

    always #5 mclk = ~mclk;

    tick_gen_n #(
        .CLK_HZ (10),
        .NCH    (NCH),
        .W      (W)
    ) dut (
        .mclk    (mclk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .casc    (casc),
        .start   (start),
        .stop    (stop),
        .wr      (wr),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .rco     (rco),
        .busy    (busy),
        .cnt     (cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later, and retire any single-cycle pulses.
    task automatic tick();
        @(posedge mclk);
        #1;
        start = '0;
        stop  = '0;
        wr    = 1'b0;
    endtask

    task automatic wr_tc(input int ch, input int val);
        wr      = 1'b1;
        wr_ch   = ch[0];
        wr_data = val[7:0];
        tick();
    endtask

    task automatic wait_rco(input int ch, input int max, output int cycles);
        cycles = 0;
        while (1) begin
            tick();
            cycles++;
            if (rco[ch]) break;
            if (cycles > max) break;
        end
    endtask

    task automatic count_rco(input int ch, input int ncyc, output int pulses);
        pulses = 0;
        repeat (ncyc) begin
            tick();
            if (rco[ch]) pulses++;
        end
    endtask

    function automatic int cnt0();
        return int'(cnt[7:0]);
    endfunction

    function automatic int cnt1();
        return int'(cnt[15:8]);
    endfunction

    initial begin
        #3;
        chk("rst_rco", int'(rco), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt), 0);
        repeat (2) @(posedge mclk);
        #1 reset = 1'b1;

        // Periodic ch0 with the reset terminal count of 9
        en = 2'b01; mode = 2'b00; casc = 2'b00;
        start = 2'b01;
        wait_rco(0, 40, n);  chk("per_first", n, 11);
        chk("per_cnt_at_rco", cnt0(), 0);
        chk("per_busy", int'(busy[0]), 1);
        wait_rco(0, 40, n);  chk("per_period1", n, 10);
        wait_rco(0, 40, n);  chk("per_period2", n, 10);
        tick();              chk("per_rco_width", int'(rco[0]), 0);
        stop = 2'b01; tick();
        chk("stop_busy", int'(busy[0]), 0);
        chk("stop_cnt", cnt0(), 0);

        // One-shot, tc=3
        wr_tc(0, 3);
        mode = 2'b01;
        start = 2'b01;
        wait_rco(0, 40, n);  chk("os_latency", n, 5);
        chk("os_busy_drop", int'(busy[0]), 0);
        count_rco(0, 20, n); chk("os_no_more", n, 0);

        // Cascade: ch0 tc=1, ch1 tc=2 counting ch0 pulses
        mode = 2'b00;
        wr_tc(0, 1);
        wr_tc(1, 2);
        casc = 2'b10; en = 2'b11;
        start = 2'b11;
        wait_rco(1, 40, n);  chk("casc_first", n, 8);
        wait_rco(1, 40, n);  chk("casc_period1", n, 6);
        wait_rco(1, 40, n);  chk("casc_period2", n, 6);
        chk("casc_cnt1", cnt1(), 0);
        en = 2'b01;
        count_rco(1, 4, n);  chk("casc_paused", n, 0);
        en = 2'b11;
        wait_rco(1, 40, n);  chk("casc_delayed", n, 6);
        stop = 2'b11; tick();

        // Lowering tc below the running count
        casc = 2'b00; en = 2'b01;
        wr_tc(0, 9);
        start = 2'b01; tick();
        chk("tcw_cnt_start", cnt0(), 0);
        repeat (7) tick();
        chk("tcw_cnt7", cnt0(), 7);
        wr_tc(0, 4);
        chk("tcw_cnt_wr_edge", cnt0(), 8);
        tick();
        chk("tcw_wrap_cnt", cnt0(), 0);
        chk("tcw_wrap_rco", int'(rco[0]), 1);
        wait_rco(0, 40, n);  chk("tcw_period1", n, 5);
        wait_rco(0, 40, n);  chk("tcw_period2", n, 5);
        stop = 2'b11; tick();

        // tc=0: rco held high, en low stops it
        en = 2'b10;
        wr_tc(1, 0);
        start = 2'b10;
        wait_rco(1, 40, n);  chk("tc0_first", n, 2);
        count_rco(1, 5, n);  chk("tc0_continuous", n, 5);
        en = 2'b00; tick();
        chk("tc0_en_low_rco", int'(rco[1]), 0);
        chk("tc0_en_low_busy", int'(busy[1]), 1);
        stop = 2'b11; tick();

        // Start and stop together
        en = 2'b01;
        start = 2'b01; stop = 2'b01; tick();
        chk("ss_busy", int'(busy[0]), 0);
        chk("ss_cnt", cnt0(), 0);
        tick();
        chk("ss_busy_later", int'(busy[0]), 0);

        // Reset mid-count
        wr_tc(0, 7);
        start = 2'b01; tick();
        repeat (5) tick();
        chk("rmid_cnt5", cnt0(), 5);
        #2 reset = 1'b0;
        #1;
        chk("rmid_async_cnt", cnt0(), 0);
        chk("rmid_async_busy", int'(busy), 0);
        chk("rmid_async_rco", int'(rco), 0);
        @(posedge mclk);
        @(posedge mclk);
        #1 reset = 1'b1;
        count_rco(0, 20, n); chk("rmid_no_rco", n, 0);
        chk("rmid_cnt_after", cnt0(), 0);
        chk("rmid_busy_after", int'(busy[0]), 0);
        start = 2'b01;
        wait_rco(0, 40, n);  chk("rmid_tc_ch0", n, 11);
        stop = 2'b01; tick();
        en = 2'b10;
        start = 2'b10;
        wait_rco(1, 40, n);  chk("rmid_tc_ch1", n, 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
